// File: rtl/booth_mul_arbiter_if.sv
// Requester and multiplier bus for the Booth multiplier arbiter.
// slave = the arbiter; master = whoever drives requests and models the multiplier.
interface booth_mul_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 32
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [2*W-1:0]     result;
    logic               err;
    logic               busy;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic               mul_beg;
    logic [2*W-1:0]     mul_c;
    logic               mul_finish;

    modport slave (
        input  req, a_in, b_in, mul_c, mul_finish,
        output gnt, done, result, err, busy, mul_a, mul_b, mul_beg
    );

    modport master (
        output req, a_in, b_in, mul_c, mul_finish,
        input  gnt, done, result, err, busy, mul_a, mul_b, mul_beg
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle signed Booth multiplier among N_REQ requesters,
// with a RUN watchdog and a stale-finish guard.
module booth_mul_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned MIN_RUN = 2
) (
    input logic                CLK,
    input logic                RST,
    booth_mul_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, owner_q, winner, rr_next;
    logic [SUM_W-1:0]   cand;
    logic               found;
    logic [W-1:0]       a_sel, b_sel;
    logic [CNT_W-1:0]   run_cnt_q;
    logic [W-1:0]       mul_a_q, mul_b_q;
    logic [2*W-1:0]     result_q;
    logic               err_q;
    logic               fin_ok, tmo;
    logic [N_REQ-1:0]   owner_oh;

    // Early finish flags may be left over from the previous operation, so ignore them.
    assign fin_ok = bus.mul_finish && (run_cnt_q >= CNT_W'(MIN_RUN));
    assign tmo    = (run_cnt_q == CNT_W'(TIMEOUT - 1));

    // First request at or after rr_ptr, searching upward with wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (cand >= SUM_W'(N_REQ)) cand = cand - SUM_W'(N_REQ);
            if (!found && bus.req[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                a_sel = bus.a_in[i*W +: W];
                b_sel = bus.b_in[i*W +: W];
            end
        end
        rr_next = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (fin_ok || tmo) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            run_cnt_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        mul_a_q  <= a_sel;
                        mul_b_q  <= b_sel;
                        owner_q  <= winner;
                        rr_ptr_q <= rr_next;
                    end
                end
                StLoad: run_cnt_q <= '0;
                StRun: begin
                    run_cnt_q <= run_cnt_q + 1'b1;
                    if (fin_ok) begin
                        result_q <= bus.mul_c;
                        err_q    <= 1'b0;
                    end else if (tmo) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        bus.gnt           = '0;
        bus.done          = '0;
        bus.err           = 1'b0;
        bus.busy          = (state_q != StIdle);
        bus.mul_beg       = (state_q == StRun);
        unique case (state_q)
            StLoad: bus.gnt = owner_oh;
            StDone: begin
                bus.done = owner_oh;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

    assign bus.mul_a  = mul_a_q;
    assign bus.mul_b  = mul_b_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: behavioural multiplier model with a fixed 17-cycle
// latency, plus a stale-then-hang mode to exercise the watchdog.
module tb_booth_mul_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 32;
    localparam int          LAT = 17;

    logic CLK = 1'b0;
    logic RST;
    logic stale_mode = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   run_cyc;
    int   gnt_cnt = 0, done_cnt = 0, overlap = 0;
    logic signed [63:0] pa, pb;

    always #5 CLK = ~CLK;

    booth_mul_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    booth_mul_arbiter #(
        .N_REQ  (N),
        .W      (W),
        .TIMEOUT(TMO),
        .MIN_RUN(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Multiplier model: run_cyc is the index of the current RUN cycle.
    always @(posedge CLK or posedge RST) begin
        if (RST)               run_cyc <= 0;
        else if (!bus.mul_beg) run_cyc <= 0;
        else                   run_cyc <= run_cyc + 1;
    end
    assign pa = $signed(bus.mul_a);
    assign pb = $signed(bus.mul_b);
    assign bus.mul_c = pa * pb;
    assign bus.mul_finish = bus.mul_beg && (stale_mode ? (run_cyc < 2) : (run_cyc >= LAT - 1));

    always @(negedge CLK) begin
        if (bus.gnt != '0) gnt_cnt <= gnt_cnt + 1;
        if (bus.done != '0) done_cnt <= done_cnt + 1;
        if (bus.gnt != '0 && bus.done != '0) overlap <= overlap + 1;
    end

    logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [63:0] exp_r [5] = '{64'hFFFFFFFFFFFFFFD6, 64'h00000006FC23AC00,
                               64'h4000000000000000, 64'hFFFFFFFF80000001,
                               64'hFFFFFFFFFFFFFFD6};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        bus.a_in[idx*W +: W] = a;
        bus.b_in[idx*W +: W] = b;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.gnt != '0) begin
                g = bus.gnt;
                break;
            end
        end
    endtask

    task automatic wait_done(output logic [3:0] d, output int n);
        d = '0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            n++;
            if (bus.done != '0) begin
                d = bus.done;
                break;
            end
        end
    endtask

    logic [3:0] g, d;
    int         n, done_before;

    initial begin
        RST = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        @(negedge CLK);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_beg", bus.mul_beg, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Single request, gnt one cycle after req is sampled.
        @(negedge CLK);
        set_op(0, 32'd3, 32'd5);
        bus.req = 4'b0001;
        @(negedge CLK);
        chk("t1_gnt", bus.gnt, 4'b0001);
        chk("t1_mul_a", bus.mul_a, 32'd3);
        chk("t1_mul_b", bus.mul_b, 32'd5);
        bus.req = '0;
        wait_done(d, n);
        chk("t1_done", d, 4'b0001);
        chk("t1_result", bus.result, 64'd15);
        chk("t1_err", bus.err, 0);
        chk("t1_lat", n, 18);
        @(negedge CLK);
        chk("t1_busy_after", bus.busy, 0);
        chk("t1_result_held", bus.result, 64'd15);

        // Signed operands on requester 2.
        set_op(2, 32'hFFFFFFFE, 32'd7);
        bus.req = 4'b0100;
        wait_gnt(g);
        chk("t2_gnt", g, 4'b0100);
        bus.req = '0;
        wait_done(d, n);
        chk("t2_done", d, 4'b0100);
        chk("t2_result", bus.result, 64'hFFFFFFFFFFFFFFF2);
        chk("t2_err", bus.err, 0);

        // Serve requester 3, then 1001 must go to 0 before 3.
        set_op(3, 32'd6, 32'd7);
        bus.req = 4'b1000;
        wait_gnt(g);
        chk("t3_gnt", g, 4'b1000);
        bus.req = '0;
        wait_done(d, n);
        chk("t3_result", bus.result, 64'd42);
        set_op(0, 32'd9, 32'd9);
        set_op(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        bus.req = 4'b1001;
        wait_gnt(g);
        chk("wrap_gnt0", g, 4'b0001);
        wait_done(d, n);
        chk("wrap_done0", d, 4'b0001);
        chk("wrap_result0", bus.result, 64'd81);
        wait_gnt(g);
        chk("wrap_gnt1", g, 4'b1000);
        bus.req = '0;
        wait_done(d, n);
        chk("wrap_done1", d, 4'b1000);
        chk("wrap_result1", bus.result, 64'd1);

        // Round robin with all four requesting continuously.
        set_op(0, 32'd7, 32'hFFFFFFFA);
        set_op(1, 32'd100000, 32'd300000);
        set_op(2, 32'h80000000, 32'h80000000);
        set_op(3, 32'h7FFFFFFF, 32'hFFFFFFFF);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g);
            chk($sformatf("rr%0d_gnt", k), g, exp_g[k]);
            if (k == 4) bus.req = '0;
            wait_done(d, n);
            chk($sformatf("rr%0d_done", k), d, exp_g[k]);
            chk($sformatf("rr%0d_result", k), bus.result, exp_r[k]);
        end

        // Stale finish ignored, then the multiplier hangs and the watchdog fires.
        stale_mode = 1'b1;
        set_op(1, 32'd5, 32'd5);
        bus.req = 4'b0010;
        wait_gnt(g);
        chk("tmo_gnt", g, 4'b0010);
        bus.req = '0;
        wait_done(d, n);
        chk("tmo_done", d, 4'b0010);
        chk("tmo_err", bus.err, 1);
        chk("tmo_result", bus.result, 0);
        chk("tmo_lat", n, 33);
        stale_mode = 1'b0;

        set_op(2, 32'hFFFFFFFD, 32'hFFFFFFFD);
        bus.req = 4'b0100;
        wait_gnt(g);
        chk("post_tmo_gnt", g, 4'b0100);
        bus.req = '0;
        wait_done(d, n);
        chk("post_tmo_done", d, 4'b0100);
        chk("post_tmo_result", bus.result, 64'd9);
        chk("post_tmo_err", bus.err, 0);

        // Reset during RUN abandons the operation and clears rr_ptr.
        set_op(2, 32'd4, 32'd4);
        bus.req = 4'b0100;
        wait_gnt(g);
        chk("rst_op_gnt", g, 4'b0100);
        bus.req = '0;
        repeat (5) @(negedge CLK);
        chk("rst_op_busy", bus.busy, 1);
        chk("rst_op_beg", bus.mul_beg, 1);
        #1;
        done_before = done_cnt;
        RST = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_beg", bus.mul_beg, 0);
        chk("mid_rst_mul_a", bus.mul_a, 0);
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_gnt", bus.gnt, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        #1;
        chk("mid_rst_no_done", done_cnt, done_before);
        set_op(1, 32'd11, 32'hFFFFFFFE);
        set_op(3, 32'd1, 32'd1);
        bus.req = 4'b1010;
        wait_gnt(g);
        chk("after_rst_gnt", g, 4'b0010);
        bus.req = '0;
        wait_done(d, n);
        chk("after_rst_done", d, 4'b0010);
        chk("after_rst_result", bus.result, 64'hFFFFFFFFFFFFFFEA);

        @(negedge CLK);
        #1;
        chk("total_gnt", gnt_cnt, 14);
        chk("total_done", done_cnt, 13);
        chk("gnt_done_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
